// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 1rw SRAM front-end.
// State encoding and the macro geometry live here.
package sram_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CAP,
    S_RSP
  } state_e;

endpackage

// File: rtl/sram_data_iobuf.sv
// Tri-state driver and input tap for the macro DATA bus.
// Pad is released whenever the enable is low.
module sram_data_iobuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_oe,
  input  logic [DATA_WIDTH-1:0] i_dout,
  output logic [DATA_WIDTH-1:0] o_din,
  inout  wire  [DATA_WIDTH-1:0] io_pad
);

  // drive the pad only while enabled
  assign io_pad = i_oe ? i_dout : {DATA_WIDTH{1'bz}};

  // observe whatever is on the pad
  assign o_din  = io_pad;

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Valid/ready front-end for a single-port 1rw SRAM macro.
// Sequences CSb/WEb/OEb/ADDR/DATA and buffers one read response.
module sram_1rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  state_e r_state;
  state_e w_state_nxt;

  logic                  r_csb, r_web, r_oeb;
  logic                  r_drv_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_csb_nxt, w_web_nxt, w_oeb_nxt;
  logic                  w_drv_en_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic                  w_rsp_valid_nxt;
  logic                  w_cap;
  logic [DATA_WIDTH-1:0] w_din;

  // state register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (req_valid) w_state_nxt = req_we ? S_WR : S_RD;
      S_WR:   w_state_nxt = S_IDLE;
      S_RD:   w_state_nxt = S_CAP;
      S_CAP:  w_state_nxt = S_RSP;
      S_RSP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // next values for the registered macro pins and response
  always_comb begin
    w_csb_nxt       = r_csb;
    w_web_nxt       = r_web;
    w_oeb_nxt       = r_oeb;
    w_drv_en_nxt    = r_drv_en;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_cap           = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_addr_nxt = req_addr;
          w_csb_nxt  = 1'b0;
          if (req_we) begin
            w_web_nxt    = 1'b0;
            w_oeb_nxt    = 1'b1;
            w_drv_en_nxt = 1'b1;
            w_wdata_nxt  = req_wdata;
          end else begin
            w_web_nxt    = 1'b1;
            w_oeb_nxt    = 1'b0;
            w_drv_en_nxt = 1'b0;
          end
        end
      end
      S_WR: begin
        w_csb_nxt    = 1'b1;
        w_web_nxt    = 1'b1;
        w_drv_en_nxt = 1'b0;
      end
      S_RD: begin
        w_csb_nxt = 1'b0;
        w_web_nxt = 1'b1;
        w_oeb_nxt = 1'b0;
      end
      S_CAP: begin
        w_cap           = 1'b1;
        w_rsp_valid_nxt = 1'b1;
        w_csb_nxt       = 1'b1;
        w_oeb_nxt       = 1'b1;
      end
      S_RSP: begin
        if (rsp_ready) w_rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // register macro pins and the response slot
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_csb       <= 1'b1;
      r_web       <= 1'b1;
      r_oeb       <= 1'b1;
      r_drv_en    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_csb       <= w_csb_nxt;
      r_web       <= w_web_nxt;
      r_oeb       <= w_oeb_nxt;
      r_drv_en    <= w_drv_en_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_cap) r_rsp_rdata <= w_din;
    end
  end

  sram_data_iobuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iobuf (
    .i_oe  (r_drv_en),
    .i_dout(r_wdata),
    .o_din (w_din),
    .io_pad(sram_data)
  );

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign sram_addr = r_addr;
  assign sram_csb  = r_csb;
  assign sram_web  = r_web;
  assign sram_oeb  = r_oeb;

endmodule
